// File: rtl/serial_pattern_detector.sv
// Serial N-bit pattern detector with runtime-loadable pattern, saturating match count and overlap select.
// Registered match pulse one cycle after the completing bit; no backpressure, one qualified bit accepted per cycle.
module serial_pattern_detector #(
  parameter int             N           = 4,
  parameter int             OVERLAP     = 1,
  parameter int             CNT_W       = 8,
  parameter logic [N-1:0]   PATTERN_RST = N'(4'b1011)
) (
  input  logic                       clk,
  input  logic                       Reset_n,
  input  logic                       cfg_we,
  input  logic [N-1:0]               cfg_pattern,
  input  logic                       Din_valid,
  input  logic                       Din,
  output logic                       Dout,
  output logic [CNT_W-1:0]           match_count,
  output logic [N-1:0]               pattern,
  output logic [$clog2(N+1)-1:0]     fill
);

  localparam int             FW        = $clog2(N+1);
  localparam logic [FW-1:0]  FILL_FULL = FW'(N);

  typedef enum logic [1:0] {EMPTY, FILLING, ARMED} state_t;

  state_t            state;
  logic [N-1:0]      history;
  logic [N-1:0]      shifted;
  logic [N-1:0]      next_hist;
  logic [N-1:0]      next_pattern;
  logic [FW-1:0]     shifted_fill;
  logic [FW-1:0]     next_fill;
  logic [CNT_W-1:0]  next_count;
  logic              next_dout;
  logic              hit;

  // fill is the state register; the FSM view is decoded from it
  always_comb begin
    if (fill == '0)
      state = EMPTY;
    else if (fill == FILL_FULL)
      state = ARMED;
    else
      state = FILLING;
  end

  always_comb begin
    shifted      = {history[N-2:0], Din};
    shifted_fill = (state == ARMED) ? FILL_FULL : fill + FW'(1);
    hit          = 1'b0;
    next_hist    = history;
    next_fill    = fill;
    next_count   = match_count;
    next_pattern = pattern;
    next_dout    = 1'b0;
    if (cfg_we) begin
      // a bit arriving alongside a pattern load is dropped
      next_pattern = cfg_pattern;
      next_hist    = '0;
      next_fill    = '0;
      next_count   = '0;
    end else if (Din_valid) begin
      hit       = (shifted_fill == FILL_FULL) && (shifted == pattern);
      next_hist = shifted;
      next_fill = shifted_fill;
      if (hit) begin
        next_dout = 1'b1;
        if (match_count != '1)
          next_count = match_count + CNT_W'(1);
        if (OVERLAP == 0) begin
          next_hist = '0;
          next_fill = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pattern     <= PATTERN_RST;
      history     <= '0;
      fill        <= '0;
      match_count <= '0;
      Dout        <= 1'b0;
    end else begin
      pattern     <= next_pattern;
      history     <= next_hist;
      fill        <= next_fill;
      match_count <= next_count;
      Dout        <= next_dout;
    end
  end

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed bench: overlapping (ov), non-overlapping (no) and 2-bit/2-bit-count (sat) instances share one bit stream.
module tb_serial_pattern_detector;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic       cfg_we;
  logic [3:0] cfg_pat4;
  logic [1:0] cfg_pat2;
  logic       Din_valid;
  logic       Din;

  logic       dout_ov,  dout_no,  dout_sat;
  logic [7:0] cnt_ov,   cnt_no;
  logic [1:0] cnt_sat;
  logic [3:0] pat_ov,   pat_no;
  logic [1:0] pat_sat;
  logic [2:0] fill_ov,  fill_no;
  logic [1:0] fill_sat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_pattern_detector #(.N(4), .OVERLAP(1), .CNT_W(8), .PATTERN_RST(4'b1011)) u_ov (
    .clk(clk), .Reset_n(Reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pat4),
    .Din_valid(Din_valid), .Din(Din), .Dout(dout_ov), .match_count(cnt_ov),
    .pattern(pat_ov), .fill(fill_ov));

  serial_pattern_detector #(.N(4), .OVERLAP(0), .CNT_W(8), .PATTERN_RST(4'b1011)) u_no (
    .clk(clk), .Reset_n(Reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pat4),
    .Din_valid(Din_valid), .Din(Din), .Dout(dout_no), .match_count(cnt_no),
    .pattern(pat_no), .fill(fill_no));

  serial_pattern_detector #(.N(2), .OVERLAP(1), .CNT_W(2), .PATTERN_RST(2'b11)) u_sat (
    .clk(clk), .Reset_n(Reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pat2),
    .Din_valid(Din_valid), .Din(Din), .Dout(dout_sat), .match_count(cnt_sat),
    .pattern(pat_sat), .fill(fill_sat));

  typedef struct {
    logic we;
    logic v;
    logic d;
    int   d_ov;
    int   c_ov;
    int   f_ov;
    int   d_no;
    int   c_no;
    int   f_no;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // drive one cycle of inputs, then sample just after the edge
  task automatic step(input logic we, input logic v, input logic d);
    cfg_we    = we;
    Din_valid = v;
    Din       = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          we v  d  d_ov c_ov f_ov d_no c_no f_no
    vecs[0]  = '{0, 1, 1, 0, 0, 1, 0, 0, 1};
    vecs[1]  = '{0, 1, 0, 0, 0, 2, 0, 0, 2};
    vecs[2]  = '{0, 1, 1, 0, 0, 3, 0, 0, 3};
    vecs[3]  = '{0, 1, 1, 1, 1, 4, 1, 1, 0};
    vecs[4]  = '{0, 1, 0, 0, 1, 4, 0, 1, 1};
    vecs[5]  = '{0, 1, 1, 0, 1, 4, 0, 1, 2};
    vecs[6]  = '{0, 1, 1, 1, 2, 4, 0, 1, 3};
    vecs[7]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{0, 1, 1, 0, 0, 1, 0, 0, 1};
    vecs[9]  = '{0, 1, 0, 0, 0, 2, 0, 0, 2};
    vecs[10] = '{0, 0, 1, 0, 0, 2, 0, 0, 2};
    vecs[11] = '{0, 0, 1, 0, 0, 2, 0, 0, 2};
    vecs[12] = '{0, 1, 1, 0, 0, 3, 0, 0, 3};
    vecs[13] = '{0, 0, 0, 0, 0, 3, 0, 0, 3};
    vecs[14] = '{0, 0, 1, 0, 0, 3, 0, 0, 3};
    vecs[15] = '{0, 0, 0, 0, 0, 3, 0, 0, 3};
    vecs[16] = '{0, 1, 1, 1, 1, 4, 1, 1, 0};
    vecs[17] = '{0, 0, 1, 0, 1, 4, 0, 1, 0};

    Reset_n   = 1'b0;
    cfg_we    = 1'b0;
    cfg_pat4  = 4'b1011;
    cfg_pat2  = 2'b11;
    Din_valid = 1'b0;
    Din       = 1'b0;
    #12;
    chk("rst_pattern", int'(pat_ov), 11);
    chk("rst_pattern_sat", int'(pat_sat), 3);
    chk("rst_fill", int'(fill_ov), 0);
    chk("rst_count", int'(cnt_ov), 0);
    chk("rst_dout", int'(dout_ov), 0);
    @(negedge clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].we, vecs[i].v, vecs[i].d);
      chk($sformatf("vec%0d_dout_ov", i), int'(dout_ov), vecs[i].d_ov);
      chk($sformatf("vec%0d_cnt_ov", i),  int'(cnt_ov),  vecs[i].c_ov);
      chk($sformatf("vec%0d_fill_ov", i), int'(fill_ov), vecs[i].f_ov);
      chk($sformatf("vec%0d_dout_no", i), int'(dout_no), vecs[i].d_no);
      chk($sformatf("vec%0d_cnt_no", i),  int'(cnt_no),  vecs[i].c_no);
      chk($sformatf("vec%0d_fill_no", i), int'(fill_no), vecs[i].f_no);
    end

    // saturating counter on the 2-bit instance: six 1s against pattern 11
    step(1, 0, 0);
    chk("sat_pattern", int'(pat_sat), 3);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1);
      chk($sformatf("sat%0d_dout", i), int'(dout_sat), (i == 0) ? 0 : 1);
      chk($sformatf("sat%0d_cnt", i), int'(cnt_sat), (i < 3) ? i : 3);
      chk($sformatf("sat%0d_fill", i), int'(fill_sat), (i == 0) ? 1 : 2);
    end

    // pattern load with a simultaneous valid bit, after a partial window
    step(1, 0, 0);
    step(0, 1, 1);
    step(0, 1, 0);
    step(0, 1, 1);
    chk("cfg_pre_fill", int'(fill_ov), 3);
    cfg_pat4 = 4'b0110;
    step(1, 1, 1);
    chk("cfg_pattern", int'(pat_ov), 6);
    chk("cfg_fill", int'(fill_ov), 0);
    chk("cfg_count", int'(cnt_ov), 0);
    chk("cfg_dout", int'(dout_ov), 0);
    step(0, 1, 0);
    chk("cfg_b0_fill", int'(fill_ov), 1);
    step(0, 1, 1);
    step(0, 1, 1);
    chk("cfg_b2_dout", int'(dout_ov), 0);
    step(0, 1, 0);
    chk("cfg_b3_dout", int'(dout_ov), 1);
    chk("cfg_b3_count", int'(cnt_ov), 1);
    step(0, 0, 0);
    chk("cfg_after_dout", int'(dout_ov), 0);

    // mid-cycle reset on the non-overlap instance with fill=3, count=5
    cfg_pat4 = 4'b1111;
    step(1, 0, 0);
    for (int i = 0; i < 23; i++) step(0, 1, 1);
    chk("prerst_fill", int'(fill_no), 3);
    chk("prerst_count", int'(cnt_no), 5);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("midrst_pattern", int'(pat_no), 11);
    chk("midrst_fill", int'(fill_no), 0);
    chk("midrst_count", int'(cnt_no), 0);
    chk("midrst_dout", int'(dout_no), 0);
    chk("midrst_pattern_ov", int'(pat_ov), 11);
    @(negedge clk);
    Reset_n = 1'b1;
    step(0, 1, 1);
    step(0, 1, 0);
    step(0, 1, 1);
    chk("postrst_b2_dout", int'(dout_no), 0);
    step(0, 1, 1);
    chk("postrst_dout", int'(dout_no), 1);
    chk("postrst_count", int'(cnt_no), 1);
    step(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_pattern_detector.md
# serial_pattern_detector

Parametrised serial sequence detector: successor to the fixed 4-state Mealy detectors in the state-machine set. Accepts one qualified bit per cycle and compares the last N received bits against a runtime-loadable N-bit pattern. Raises a registered one-cycle match pulse and keeps a saturating match count. Selectable overlapping or non-overlapping detection. Sits between a serial bit source and a status/interrupt block.

## Interface
- N, 4, pattern length in bits; legal range 2..16.
- OVERLAP, 1, 1 = overlapping detection, 0 = non-overlapping.
- CNT_W, 8, match counter width; legal range 1..16.
- PATTERN_RST, 4'b1011 (N bits), pattern value after reset.
- clk  input  1  clock; all state changes on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- cfg_we  input  1  load cfg_pattern and clear detection state.
- cfg_pattern  input  N  new pattern. The first-received bit is the MSB.
- Din_valid  input  1  Din is a valid bit this cycle.
- Din  input  1  serial data bit.
- Dout  output  1  registered match pulse.
- match_count  output  CNT_W  saturating count of matches.
- pattern  output  N  currently active pattern.
- fill  output  $clog2(N+1)  number of valid history bits, 0..N.

## Operation
- Internal state:
  - history[N-1:0]: a new bit shifts into the LSB and the oldest bit drops out of the MSB.
  - fill: counts from 0 up to N and saturates at N.
- FSM view, derived from fill:
  - EMPTY (fill=0).
  - FILLING (0<fill<N).
  - ARMED (fill=N).
- Valid bit (Din_valid=1, cfg_we=0):
  - next_hist = {history[N-2:0], Din}.
  - next_fill = min(fill+1, N).
  - hit = (next_fill==N) && (next_hist==pattern).
- On hit:
  - Dout is 1 in the following cycle.
  - match_count increments by 1 and saturates at 2^CNT_W-1. It does not wrap.
  - OVERLAP=1: history and fill update normally, so the state stays ARMED.
  - OVERLAP=0: history becomes 0 and fill becomes 0 (back to EMPTY). The bits of the matched window are not reused.
- No valid bit (Din_valid=0, cfg_we=0):
  - history, fill and match_count hold.
  - Dout is 0 in the next cycle.
  - Gaps between valid bits are transparent to detection.
- cfg_we=1:
  - pattern loads cfg_pattern.
  - history, fill and match_count clear to 0.
  - Dout is 0 in the next cycle.
  - A Din_valid bit in the same cycle is discarded; cfg_we has priority.
- Reset (Reset_n=0), asynchronous, takes effect immediately, including mid-stream:
  - pattern=PATTERN_RST.
  - history=0, fill=0, match_count=0, Dout=0.
- Dout is never combinational from Din; there is no Mealy output path.

## Timing
- Latency: the bit sampled at edge k produces Dout=1 in the cycle after edge k, and it is visible before edge k+1.
- Dout high lasts exactly one cycle per match. Back-to-back matches are possible only with OVERLAP=1.
  - Example: a pattern of all 1s with continuous 1s gives Dout=1 every cycle after the first N bits.
- match_count updates on the same edge that sets Dout.
- pattern and fill are registered and change on the edge after cfg_we.
- The first match is possible on the N-th valid bit after reset, after cfg_we, or (OVERLAP=0) after the previous match.
- Reset release: the first edge with Reset_n=1 is a normal operating edge.

## Test plan
- N=4, PATTERN_RST=1011, OVERLAP=1, continuous Din=1,0,1,1,0,1,1 -> Dout pulses one cycle after the 4th and the 7th bit; match_count=2; fill=4 at end.
- Same stream with OVERLAP=0 -> Dout pulses only after the 4th bit; match_count=1; fill=3 at end.
- Same pattern, OVERLAP=1, bits 1,0,1,1 with Din_valid=0 gaps of 0, 2 and 3 cycles between them -> a single Dout pulse one cycle after the 4th valid bit; no pulse during gaps; fill holds through gaps.
- CNT_W=2, pattern 11, OVERLAP=1, six consecutive 1s -> five Dout pulses; match_count=1,2,3,3,3.
- After 3 bits 1,0,1, assert cfg_we with cfg_pattern=0110 and Din_valid=1 in the same cycle -> pattern=0110, fill=0, match_count=0, Dout=0, bit discarded; the following bits 0,1,1,0 -> one match.
- Assert Reset_n=0 mid-cycle while fill=3 and match_count=5 -> all outputs clear immediately (pattern=PATTERN_RST); after release, 1,0,1,1 -> match_count=1.
